// File: rtl/encoder_decoder.sv
// Four-channel frame assembler: routes din to a..d by sel or an
// auto pointer and flags a complete frame until the consumer acks.
module encoder_decoder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic [1:0]       sel,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             auto_mode,
    input  logic             frame_ack,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [3:0]       wr_strobe,
    output logic             frame_valid,
    output logic             frame_err
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] FULL    = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [3:0]       filled_q, filled_d;
    logic [1:0]       ptr_q, ptr_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [3:0]       wr_strobe_q, wr_strobe_d;
    logic             frame_valid_q, frame_valid_d;
    logic             frame_err_q, frame_err_d;

    logic       xfer;
    logic       eff_auto;
    logic [1:0] ch;
    logic [3:0] ch_oh;

    assign din_ready = (state_q != FULL);

    // Decode the destination channel and compute the next state of every flop
    always_comb begin
        xfer          = din_valid && din_ready;
        eff_auto      = (state_q == IDLE) ? auto_mode : mode_q;
        ch            = eff_auto ? ptr_q : sel;
        ch_oh         = 4'b0001 << ch;
        state_d       = state_q;
        filled_d      = filled_q;
        ptr_d         = ptr_q;
        mode_d        = mode_q;
        a_d           = a_q;
        b_d           = b_q;
        c_d           = c_q;
        d_d           = d_q;
        wr_strobe_d   = 4'b0000;
        frame_err_d   = 1'b0;

        if (xfer) begin
            wr_strobe_d = ch_oh;
            frame_err_d = |(filled_q & ch_oh);
            filled_d    = filled_q | ch_oh;
            if (eff_auto) ptr_d = ptr_q + 2'd1;
            case (ch)
                2'd0:    a_d = din;
                2'd1:    b_d = din;
                2'd2:    c_d = din;
                default: d_d = din;
            endcase
        end

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d = COLLECT;
                    mode_d  = auto_mode;
                end
            end
            COLLECT: begin
                if (filled_d == 4'b1111) state_d = FULL;
            end
            FULL: begin
                if (frame_ack) begin
                    state_d  = IDLE;
                    filled_d = 4'b0000;
                    ptr_d    = 2'd0;
                end
            end
            default: begin
                state_d  = IDLE;
                filled_d = 4'b0000;
                ptr_d    = 2'd0;
            end
        endcase

        frame_valid_d = (state_d == FULL);
    end

    // State and output registers; reset discards any frame in progress
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            filled_q      <= 4'b0000;
            ptr_q         <= 2'd0;
            mode_q        <= 1'b0;
            a_q           <= '0;
            b_q           <= '0;
            c_q           <= '0;
            d_q           <= '0;
            wr_strobe_q   <= 4'b0000;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            filled_q      <= filled_d;
            ptr_q         <= ptr_d;
            mode_q        <= mode_d;
            a_q           <= a_d;
            b_q           <= b_d;
            c_q           <= c_d;
            d_q           <= d_d;
            wr_strobe_q   <= wr_strobe_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
        end
    end

    assign a           = a_q;
    assign b           = b_q;
    assign c           = c_q;
    assign d           = d_q;
    assign wr_strobe   = wr_strobe_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_encoder_decoder.sv
// Directed bench for encoder_decoder: manual/auto frames, duplicate
// writes, async reset mid-frame, ack with a pending word.
module tb_encoder_decoder;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic [1:0] sel;
    logic       din_valid;
    logic       din_ready;
    logic       auto_mode;
    logic       frame_ack;
    logic [7:0] a, b, c, d;
    logic [3:0] wr_strobe;
    logic       frame_valid;
    logic       frame_err;

    int n_checks = 0;
    int n_fail   = 0;

    encoder_decoder #(.WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .sel         (sel),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .auto_mode   (auto_mode),
        .frame_ack   (frame_ack),
        .a           (a),
        .b           (b),
        .c           (c),
        .d           (d),
        .wr_strobe   (wr_strobe),
        .frame_valid (frame_valid),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [1:0] s, input logic [7:0] v);
        din_valid = 1'b1;
        sel       = s;
        din       = v;
        tick();
    endtask

    initial begin
        rst       = 1'b1;
        din       = 8'h00;
        sel       = 2'd0;
        din_valid = 1'b0;
        auto_mode = 1'b0;
        frame_ack = 1'b0;
        #12;
        chk("rst_a", a, 8'h00);
        chk("rst_d", d, 8'h00);
        chk("rst_wr", wr_strobe, 4'h0);
        chk("rst_fv", frame_valid, 1'b0);
        chk("rst_err", frame_err, 1'b0);
        chk("rst_rdy", din_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // manual frame
        put(2'd0, 8'h24);
        chk("m1_a", a, 8'h24);
        chk("m1_wr", wr_strobe, 4'b0001);
        chk("m1_fv", frame_valid, 1'b0);
        put(2'd1, 8'h81);
        chk("m2_b", b, 8'h81);
        chk("m2_wr", wr_strobe, 4'b0010);
        put(2'd2, 8'h09);
        chk("m3_c", c, 8'h09);
        chk("m3_wr", wr_strobe, 4'b0100);
        chk("m3_fv", frame_valid, 1'b0);
        put(2'd3, 8'h63);
        chk("m4_d", d, 8'h63);
        chk("m4_wr", wr_strobe, 4'b1000);
        chk("m4_fv", frame_valid, 1'b1);
        chk("m4_rdy", din_ready, 1'b0);
        chk("m4_err", frame_err, 1'b0);
        din_valid = 1'b0;
        tick();
        chk("m5_wr", wr_strobe, 4'b0000);
        chk("m5_fv", frame_valid, 1'b1);
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        chk("mack_fv", frame_valid, 1'b0);
        chk("mack_rdy", din_ready, 1'b1);
        chk("mack_a", a, 8'h24);

        // auto frame, sel held at 3
        auto_mode = 1'b1;
        put(2'd3, 8'h0D);
        chk("a1_a", a, 8'h0D);
        chk("a1_wr", wr_strobe, 4'b0001);
        put(2'd3, 8'h8D);
        chk("a2_b", b, 8'h8D);
        put(2'd3, 8'h65);
        chk("a3_c", c, 8'h65);
        put(2'd3, 8'h12);
        chk("a4_d", d, 8'h12);
        chk("a4_wr", wr_strobe, 4'b1000);
        chk("a4_fv", frame_valid, 1'b1);
        din_valid = 1'b0;
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        chk("aack_fv", frame_valid, 1'b0);

        // next auto frame starts at a; reset it after two words
        put(2'd3, 8'h77);
        chk("p0_a", a, 8'h77);
        put(2'd3, 8'h88);
        chk("p1_b", b, 8'h88);
        din_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("ar_a", a, 8'h00);
        chk("ar_b", b, 8'h00);
        chk("ar_c", c, 8'h00);
        chk("ar_wr", wr_strobe, 4'h0);
        chk("ar_rdy", din_ready, 1'b1);
        #1;
        rst = 1'b0;
        tick();

        // fresh manual frame after reset
        auto_mode = 1'b0;
        put(2'd3, 8'h11);
        put(2'd2, 8'h22);
        put(2'd1, 8'h33);
        chk("f3_fv", frame_valid, 1'b0);
        chk("f3_rdy", din_ready, 1'b1);
        put(2'd0, 8'h44);
        chk("f4_fv", frame_valid, 1'b1);
        chk("f4_abcd", {a, b, c, d}, 32'h44332211);
        din_valid = 1'b0;
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;

        // duplicate write to c
        put(2'd2, 8'hAA);
        chk("dup1_err", frame_err, 1'b0);
        put(2'd2, 8'h55);
        chk("dup2_c", c, 8'h55);
        chk("dup2_err", frame_err, 1'b1);
        chk("dup2_wr", wr_strobe, 4'b0100);
        chk("dup2_fv", frame_valid, 1'b0);
        chk("dup2_rdy", din_ready, 1'b1);

        // auto_mode raised mid-frame: still routed by sel
        auto_mode = 1'b1;
        put(2'd3, 8'hD3);
        chk("tg1_d", d, 8'hD3);
        chk("tg1_a", a, 8'h44);
        chk("tg1_err", frame_err, 1'b0);
        put(2'd1, 8'hB1);
        chk("tg2_b", b, 8'hB1);
        chk("tg2_fv", frame_valid, 1'b0);
        put(2'd0, 8'hA0);
        chk("tg3_a", a, 8'hA0);
        chk("tg3_fv", frame_valid, 1'b1);

        // word held across FULL and the ack edge
        auto_mode = 1'b0;
        put(2'd1, 8'h5A);
        chk("hf_b", b, 8'hB1);
        chk("hf_wr", wr_strobe, 4'b0000);
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
        chk("hk_b", b, 8'hB1);
        chk("hk_wr", wr_strobe, 4'b0000);
        chk("hk_rdy", din_ready, 1'b1);
        chk("hk_fv", frame_valid, 1'b0);
        tick();
        chk("hi_b", b, 8'h5A);
        chk("hi_wr", wr_strobe, 4'b0010);
        chk("hi_acd", {a, c, d}, 24'hA055D3);
        din_valid = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
